// File: rtl/scan_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_sequencer
// Purpose  : Drives the mux-D scan chain and primary I/O of one sequential
//            core for pattern-based hardware test. Accepts parallel patterns
//            over valid/ready and shifts each one serially into the chain.
//            PIs are applied for one capture cycle, and the captured state is
//            unloaded while the next pattern is loaded (a final flush unloads
//            the last pattern). Responses (chain state + POs) are returned in
//            order over valid/ready.
// Ports    : CK, RSTN              clock, async active-low reset
//            start                 begin a session (IDLE only)
//            pat_valid/pat_ready   pattern handshake; pat_si/pat_pi/pat_last
//            rsp_valid/rsp_ready   response handshake; rsp_so/rsp_po
//            scan_en/scan_in       core scan control (scan_en=1 shifts)
//            scan_out              core scan output (last chain flop)
//            core_pi/core_po       core primary inputs/outputs
//            busy, done, pat_cnt   session status
// Notes    : CHAIN_LEN must be at least 3.
// Revision : 1.0  initial release
// ============================================================================
module scan_test_sequencer #(
   parameter int CHAIN_LEN = 21,
   parameter int NPI       = 3,
   parameter int NPO       = 6,
   parameter int CW        = 16
) (
   input  logic                 CK,
   input  logic                 RSTN,
   input  logic                 start,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [CHAIN_LEN-1:0] pat_si,
   input  logic [NPI-1:0]       pat_pi,
   input  logic                 pat_last,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CHAIN_LEN-1:0] rsp_so,
   output logic [NPO-1:0]       rsp_po,
   output logic                 scan_en,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic [NPI-1:0]       core_pi,
   input  logic [NPO-1:0]       core_po,
   output logic                 busy,
   output logic                 done,
   output logic [CW-1:0]        pat_cnt
);

   localparam int               CNT_W    = $clog2(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD       = 3'd1,
      ST_SHIFT      = 3'd2,
      ST_CAPTURE    = 3'd3,
      ST_FLUSH_WAIT = 3'd4,
      ST_FLUSH      = 3'd5,
      ST_DONE       = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   // Bit 0 of the pattern goes straight to scan_in on accept, so only the
   // remaining CHAIN_LEN-1 bits need to be held.
   logic [CHAIN_LEN-2:0]   load_q, load_d;
   // The final unload sample bypasses this register straight into rsp_so.
   logic [CHAIN_LEN-2:0]   unload_q, unload_d;
   logic                   last_q, last_d;
   logic                   have_cap_q, have_cap_d;
   logic [NPO-1:0]         po_q, po_d;
   logic                   scan_en_q, scan_en_d;
   logic                   scan_in_q, scan_in_d;
   logic [NPI-1:0]         core_pi_q, core_pi_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [CHAIN_LEN-1:0]   rsp_so_q, rsp_so_d;
   logic [NPO-1:0]         rsp_po_q, rsp_po_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [CW-1:0]          pat_cnt_q, pat_cnt_d;

   logic                   load_ready;
   logic                   pat_accept;

   // A new pattern is only taken once the response slot is empty, so the
   // response produced at the end of its shift can never overwrite one.
   assign load_ready = (state_q == ST_LOAD) && !rsp_valid_q;
   assign pat_accept = pat_valid && load_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_d      = load_q;
      unload_d    = unload_q;
      last_d      = last_q;
      have_cap_d  = have_cap_q;
      po_d        = po_q;
      scan_en_d   = scan_en_q;
      scan_in_d   = scan_in_q;
      core_pi_d   = core_pi_q;
      rsp_valid_d = rsp_valid_q;
      rsp_so_d    = rsp_so_q;
      rsp_po_d    = rsp_po_q;
      pat_cnt_d   = pat_cnt_q;
      done_d      = 1'b0;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LOAD;
               pat_cnt_d  = '0;
               have_cap_d = 1'b0;
            end
         end

         ST_LOAD: begin
            if (pat_accept) begin
               load_d    = pat_si[CHAIN_LEN-1:1];
               scan_in_d = pat_si[0];
               core_pi_d = pat_pi;
               last_d    = pat_last;
               cnt_d     = '0;
               scan_en_d = 1'b1;
               state_d   = ST_SHIFT;
            end
         end

         ST_SHIFT, ST_FLUSH: begin
            unload_d = {scan_out, unload_q[CHAIN_LEN-2:1]};
            cnt_d    = cnt_q + 1'b1;
            if (state_q == ST_SHIFT) begin
               scan_in_d = load_q[0];
               load_d    = load_q >> 1;
            end else begin
               scan_in_d = 1'b0;
            end
            if (cnt_q == CNT_LAST) begin
               scan_en_d = 1'b0;
               scan_in_d = 1'b0;
               // The very first load of a session unloads nothing useful.
               if ((state_q == ST_FLUSH) || have_cap_q) begin
                  rsp_so_d    = {scan_out, unload_q};
                  rsp_po_d    = po_q;
                  rsp_valid_d = 1'b1;
               end
               if (state_q == ST_SHIFT) begin
                  state_d = ST_CAPTURE;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_CAPTURE: begin
            po_d       = core_po;
            pat_cnt_d  = pat_cnt_q + 1'b1;
            have_cap_d = 1'b1;
            if (!last_q) begin
               state_d = ST_LOAD;
            end else if (!rsp_valid_q) begin
               // Skip the wait state when the slot is already free.
               state_d   = ST_FLUSH;
               cnt_d     = '0;
               scan_en_d = 1'b1;
               scan_in_d = 1'b0;
            end else begin
               state_d = ST_FLUSH_WAIT;
            end
         end

         ST_FLUSH_WAIT: begin
            if (!rsp_valid_q) begin
               state_d   = ST_FLUSH;
               cnt_d     = '0;
               scan_en_d = 1'b1;
               scan_in_d = 1'b0;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         load_q      <= '0;
         unload_q    <= '0;
         last_q      <= 1'b0;
         have_cap_q  <= 1'b0;
         po_q        <= '0;
         scan_en_q   <= 1'b0;
         scan_in_q   <= 1'b0;
         core_pi_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_so_q    <= '0;
         rsp_po_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pat_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         load_q      <= load_d;
         unload_q    <= unload_d;
         last_q      <= last_d;
         have_cap_q  <= have_cap_d;
         po_q        <= po_d;
         scan_en_q   <= scan_en_d;
         scan_in_q   <= scan_in_d;
         core_pi_q   <= core_pi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_so_q    <= rsp_so_d;
         rsp_po_q    <= rsp_po_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pat_cnt_q   <= pat_cnt_d;
      end
   end

   assign pat_ready = load_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_so    = rsp_so_q;
   assign rsp_po    = rsp_po_q;
   assign scan_en   = scan_en_q;
   assign scan_in   = scan_in_q;
   assign core_pi   = core_pi_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pat_cnt   = pat_cnt_q;

endmodule
`default_nettype wire
